// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_ctrl
// Sole owner of the byte-wide RAM/IO port. Arbitrates between iCache miss
// fetches (always 4 bytes) and LSB loads/stores (1, 2 or 4 bytes), serialises
// every access into byte cycles and returns the assembled little-endian word.
// IO writes stall while the IO buffer is full; reads abort on pipeline clear.
//
// Ports
//   clk_in, rst_in (sync, active high), rdy_in (global enable), clear_in (flush)
//   iCache2memCon_enable/_address   -> memCon2iCache_return/_done
//   lsb2memCon_enable/_wr/_size/_address/_data -> memCon2lsb_return/_done
//   mem_din (RAM read data), mem_dout/mem_a/mem_wr (RAM write data/addr/strobe)
//   io_buffer_full (IO write FIFO full)
// All outputs are registered.
//
// Timing: the edge that samples a request (S) only latches it; the first byte
// address is issued on the following edge (G = S+1). The RAM returns read data
// two edges after an address is issued.
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        iCache2memCon_enable,
    input  logic [31:0] iCache2memCon_address,
    output logic [31:0] memCon2iCache_return,
    output logic        memCon2iCache_done,
    input  logic        lsb2memCon_enable,
    input  logic        lsb2memCon_wr,
    input  logic [1:0]  lsb2memCon_size,
    input  logic [31:0] lsb2memCon_address,
    input  logic [31:0] lsb2memCon_data,
    output logic [31:0] memCon2lsb_return,
    output logic        memCon2lsb_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Registered state
    state_t      r_state;
    logic [2:0]  r_cnt;        // byte/cycle counter within the access
    logic        r_last_lsb;   // last grant: 0 = iCache, 1 = LSB
    logic        r_sel_lsb;    // current access belongs to the LSB
    logic [31:0] r_addr;
    logic [2:0]  r_len;        // bytes in access: 1, 2 or 4
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;      // read bytes assembled so far
    logic [31:0] r_mem_a;
    logic [7:0]  r_mem_dout;
    logic        r_mem_wr;
    logic [31:0] r_ic_ret;
    logic        r_ic_done;
    logic [31:0] r_lsb_ret;
    logic        r_lsb_done;

    // Next-state values
    state_t      w_state_next;
    logic [2:0]  w_cnt_next;
    logic        w_last_lsb_next;
    logic        w_sel_lsb_next;
    logic [31:0] w_addr_next;
    logic [2:0]  w_len_next;
    logic [31:0] w_wdata_next;
    logic [31:0] w_rdata_next;
    logic [31:0] w_mem_a_next;
    logic [7:0]  w_mem_dout_next;
    logic        w_mem_wr_next;
    logic [31:0] w_ic_ret_next;
    logic        w_ic_done_next;
    logic [31:0] w_lsb_ret_next;
    logic        w_lsb_done_next;

    // Helpers
    logic        w_grant_ic;
    logic        w_grant_lsb;
    logic [2:0]  w_lsb_len;
    logic [31:0] w_byte_addr;
    logic        w_io_stall;
    logic        w_capturing;
    logic [1:0]  w_cap_idx;
    logic [7:0]  w_wbyte;
    logic [31:0] w_rdata_merged;

    // Round-robin on contention: favour whichever side was not served last.
    assign w_grant_ic  = iCache2memCon_enable && (!lsb2memCon_enable || r_last_lsb);
    assign w_grant_lsb = lsb2memCon_enable && (!iCache2memCon_enable || !r_last_lsb);

    assign w_lsb_len   = (lsb2memCon_size == 2'b00) ? 3'd1 :
                         (lsb2memCon_size == 2'b01) ? 3'd2 : 3'd4;

    assign w_byte_addr = r_addr + {29'd0, r_cnt};
    assign w_io_stall  = (r_addr[17:16] == IO_SEL) && io_buffer_full;
    assign w_wbyte     = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

    // Read data lags the issued address by two edges, so at count c the byte
    // arriving on mem_din belongs to index c-2.
    assign w_capturing = (r_cnt >= 3'd2);
    assign w_cap_idx   = 2'(r_cnt - 3'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign w_rdata_merged[8*gi +: 8] =
                (w_capturing && (w_cap_idx == 2'(gi))) ? mem_din : r_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_last_lsb <= 1'b0;
            r_sel_lsb  <= 1'b0;
            r_addr     <= 32'd0;
            r_len      <= 3'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
            r_ic_ret   <= 32'd0;
            r_ic_done  <= 1'b0;
            r_lsb_ret  <= 32'd0;
            r_lsb_done <= 1'b0;
        end else if (rdy_in) begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_last_lsb <= w_last_lsb_next;
            r_sel_lsb  <= w_sel_lsb_next;
            r_addr     <= w_addr_next;
            r_len      <= w_len_next;
            r_wdata    <= w_wdata_next;
            r_rdata    <= w_rdata_next;
            r_mem_a    <= w_mem_a_next;
            r_mem_dout <= w_mem_dout_next;
            r_mem_wr   <= w_mem_wr_next;
            r_ic_ret   <= w_ic_ret_next;
            r_ic_done  <= w_ic_done_next;
            r_lsb_ret  <= w_lsb_ret_next;
            r_lsb_done <= w_lsb_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_last_lsb_next = r_last_lsb;
        w_sel_lsb_next  = r_sel_lsb;
        w_addr_next     = r_addr;
        w_len_next      = r_len;
        w_wdata_next    = r_wdata;
        w_rdata_next    = r_rdata;
        w_mem_a_next    = r_mem_a;
        w_mem_dout_next = r_mem_dout;
        w_mem_wr_next   = r_mem_wr;
        w_ic_ret_next   = r_ic_ret;
        w_ic_done_next  = r_ic_done;
        w_lsb_ret_next  = r_lsb_ret;
        w_lsb_done_next = r_lsb_done;

        case (r_state)
            S_IDLE: begin
                // A flush in IDLE suppresses any grant for that cycle.
                if (!clear_in && (w_grant_ic || w_grant_lsb)) begin
                    w_state_next    = (w_grant_lsb && lsb2memCon_wr) ? S_WRITE : S_READ;
                    w_sel_lsb_next  = w_grant_lsb;
                    w_last_lsb_next = w_grant_lsb;
                    w_addr_next     = w_grant_lsb ? lsb2memCon_address : iCache2memCon_address;
                    w_len_next      = w_grant_lsb ? w_lsb_len : 3'd4;
                    w_wdata_next    = lsb2memCon_data;
                    w_cnt_next      = 3'd0;
                    w_rdata_next    = 32'd0;   // gives zero-extension for short loads
                end
            end

            S_READ: begin
                if (clear_in) begin
                    w_state_next  = S_IDLE;
                    w_mem_wr_next = 1'b0;
                    w_cnt_next    = 3'd0;
                end else begin
                    if (r_cnt < r_len) begin
                        w_mem_a_next = w_byte_addr;
                    end
                    w_rdata_next = w_rdata_merged;
                    if (r_cnt == r_len + 3'd1) begin
                        w_state_next = S_RESP;
                        if (r_sel_lsb) begin
                            w_lsb_done_next = 1'b1;
                            w_lsb_ret_next  = w_rdata_merged;
                        end else begin
                            w_ic_done_next = 1'b1;
                            w_ic_ret_next  = w_rdata_merged;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 3'd1;
                    end
                end
            end

            S_WRITE: begin
                // Stores are never aborted by clear_in.
                if (r_cnt < r_len) begin
                    if (w_io_stall) begin
                        w_mem_wr_next = 1'b0;
                    end else begin
                        w_mem_a_next    = w_byte_addr;
                        w_mem_dout_next = w_wbyte;
                        w_mem_wr_next   = 1'b1;
                        w_cnt_next      = r_cnt + 3'd1;
                    end
                end else begin
                    w_mem_wr_next   = 1'b0;
                    w_lsb_done_next = 1'b1;
                    w_state_next    = S_RESP;
                end
            end

            S_RESP: begin
                // One dead cycle so the requester can drop its enable.
                w_ic_done_next  = 1'b0;
                w_lsb_done_next = 1'b0;
                w_state_next    = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign memCon2iCache_return = r_ic_ret;
    assign memCon2iCache_done   = r_ic_done;
    assign memCon2lsb_return    = r_lsb_ret;
    assign memCon2lsb_done      = r_lsb_done;
    assign mem_dout             = r_mem_dout;
    assign mem_a                = r_mem_a;
    assign mem_wr               = r_mem_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
// Testbench for mem_ctrl: scoreboard queues filled by requester tasks from a
// transaction-level memory model, drained by a monitor watching done pulses
// and RAM write beats.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        iCache2memCon_enable;
    logic [31:0] iCache2memCon_address;
    logic [31:0] memCon2iCache_return;
    logic        memCon2iCache_done;
    logic        lsb2memCon_enable;
    logic        lsb2memCon_wr;
    logic [1:0]  lsb2memCon_size;
    logic [31:0] lsb2memCon_address;
    logic [31:0] lsb2memCon_data;
    logic [31:0] memCon2lsb_return;
    logic        memCon2lsb_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .rdy_in                (rdy_in),
        .clear_in              (clear_in),
        .iCache2memCon_enable  (iCache2memCon_enable),
        .iCache2memCon_address (iCache2memCon_address),
        .memCon2iCache_return  (memCon2iCache_return),
        .memCon2iCache_done    (memCon2iCache_done),
        .lsb2memCon_enable     (lsb2memCon_enable),
        .lsb2memCon_wr         (lsb2memCon_wr),
        .lsb2memCon_size       (lsb2memCon_size),
        .lsb2memCon_address    (lsb2memCon_address),
        .lsb2memCon_data       (lsb2memCon_data),
        .memCon2lsb_return     (memCon2lsb_return),
        .memCon2lsb_done       (memCon2lsb_done),
        .mem_din               (mem_din),
        .mem_dout              (mem_dout),
        .mem_a                 (mem_a),
        .mem_wr                (mem_wr),
        .io_buffer_full        (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    int   cyc = 0;
    logic rdy_q;
    int   checks = 0;
    int   errors = 0;
    bit   rand_done = 0;

    always @(posedge clk_in) cyc <= cyc + 1;
    always @(posedge clk_in) rdy_q <= rdy_in;

    // ---------------- memories ----------------
    logic [7:0] phys  [int unsigned];   // what the RAM really holds
    logic [7:0] model [int unsigned];   // what the program expects it to hold

    function automatic logic [7:0] dflt(input logic [31:0] a);
        logic [31:0] t;
        t = a ^ (a >> 8) ^ (a >> 17) ^ 32'h0000_005A;
        return t[7:0];
    endfunction

    function automatic logic [7:0] phys_rd(input logic [31:0] a);
        if (phys.exists(a)) return phys[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        if (model.exists(a)) return model[a];
        return dflt(a);
    endfunction

    // Synchronous RAM: one edge of read latency.
    always @(posedge clk_in) begin
        logic [7:0] rd;
        rd = phys_rd(mem_a);
        if (mem_wr) phys[mem_a] = mem_dout;
        mem_din <= rd;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk_data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  b;
        int          cyc;
    } wexp_t;

    exp_t  ic_q[$];
    exp_t  lsb_q[$];
    wexp_t wr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: only looks at cycles where outputs were actually updated.
    always @(negedge clk_in) begin
        exp_t  e;
        wexp_t w;
        if (rdy_q === 1'b1) begin
            if (memCon2iCache_done) begin
                if (ic_q.size() == 0) flag("ic_done_unexpected");
                else begin
                    e = ic_q.pop_front();
                    check("ic_return", memCon2iCache_return, e.data);
                    if (e.cyc >= 0) check("ic_done_cycle", cyc, e.cyc);
                    $display("ic done: data=%08h cycle=%0d", memCon2iCache_return, cyc);
                end
            end
            if (memCon2lsb_done) begin
                if (lsb_q.size() == 0) flag("lsb_done_unexpected");
                else begin
                    e = lsb_q.pop_front();
                    if (e.chk_data) check("lsb_return", memCon2lsb_return, e.data);
                    if (e.cyc >= 0) check("lsb_done_cycle", cyc, e.cyc);
                    $display("lsb done: data=%08h cycle=%0d", memCon2lsb_return, cyc);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) flag("wr_beat_unexpected");
                else begin
                    w = wr_q.pop_front();
                    check("wr_beat", {mem_a[23:0], mem_dout}, {w.addr[23:0], w.b});
                    if (w.cyc >= 0) check("wr_beat_cycle", cyc, w.cyc);
                end
            end
        end
    end

    // ---------------- requester tasks ----------------
    // All tasks are entered and left 1ns after a rising edge.
    task automatic sync();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_done(input bit is_lsb, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_in);
            if (rdy_q === 1'b1 && (is_lsb ? memCon2lsb_done : memCon2iCache_done)) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) flag(is_lsb ? "lsb_done_timeout" : "ic_done_timeout");
        sync();
    endtask

    task automatic ic_fetch(input logic [31:0] a, input bit chk, output int dcyc);
        exp_t e;
        e.data = {model_rd(a + 32'd3), model_rd(a + 32'd2), model_rd(a + 32'd1), model_rd(a)};
        e.cyc = chk ? cyc + 7 : -1;
        e.chk_data = 1'b1;
        ic_q.push_back(e);
        iCache2memCon_address = a;
        iCache2memCon_enable  = 1'b1;
        wait_done(1'b0, dcyc);
        iCache2memCon_enable  = 1'b0;
    endtask

    // Pushes expectations and raises the request. 'extra' cycles of delay
    // (stall/freeze/flush) apply from byte 'stall_byte' onward.
    task automatic lsb_push(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input bit chk, input int stall_byte,
                            input int extra);
        exp_t  e;
        wexp_t w;
        int    n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        e.data = 32'd0;
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                model[a + k] = d[8*k +: 8];
                w.addr = a + k;
                w.b    = d[8*k +: 8];
                w.cyc  = chk ? cyc + 2 + k + ((k >= stall_byte) ? extra : 0) : -1;
                wr_q.push_back(w);
            end
            e.chk_data = 1'b0;
            e.cyc = chk ? cyc + n + 2 + extra : -1;
        end else begin
            for (int k = 0; k < n; k++) e.data[8*k +: 8] = model_rd(a + k);
            e.chk_data = 1'b1;
            e.cyc = chk ? cyc + n + 3 + extra : -1;
        end
        lsb_q.push_back(e);
        lsb2memCon_wr      = wr;
        lsb2memCon_size    = sz;
        lsb2memCon_address = a;
        lsb2memCon_data    = d;
        lsb2memCon_enable  = 1'b1;
    endtask

    task automatic lsb_access(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d, input bit chk, output int dcyc);
        lsb_push(wr, sz, a, d, chk, 0, 0);
        wait_done(1'b1, dcyc);
        lsb2memCon_enable = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_mem_a"},      mem_a, 32'd0);
        check({tag, "_mem_dout"},   {24'd0, mem_dout}, 32'd0);
        check({tag, "_mem_wr"},     {31'd0, mem_wr}, 32'd0);
        check({tag, "_ic_done"},    {31'd0, memCon2iCache_done}, 32'd0);
        check({tag, "_lsb_done"},   {31'd0, memCon2lsb_done}, 32'd0);
        check({tag, "_ic_return"},  memCon2iCache_return, 32'd0);
        check({tag, "_lsb_return"}, memCon2lsb_return, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, d0, d1, d2, d3;
        logic [31:0] a;

        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        iCache2memCon_enable = 1'b0; iCache2memCon_address = 32'd0;
        lsb2memCon_enable = 1'b0; lsb2memCon_wr = 1'b0; lsb2memCon_size = 2'b00;
        lsb2memCon_address = 32'd0; lsb2memCon_data = 32'd0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        reset_checks("reset");
        sync();

        // 1: fetch 0x1000 with 11 22 33 44, address sweep and latency
        for (int k = 0; k < 4; k++) begin
            phys[32'h1000 + k]  = 8'(8'h11 * (k + 1));
            model[32'h1000 + k] = 8'(8'h11 * (k + 1));
        end
        n = cyc;
        fork
            ic_fetch(32'h0000_1000, 1'b1, d0);
            begin
                repeat (2) @(negedge clk_in);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk_in);
                    check("fetch_mem_a", mem_a, 32'h1000 + k);
                end
                @(negedge clk_in);
                check("fetch_mem_a_hold", mem_a, 32'h0000_1003);
                check("fetch_mem_wr_low", {31'd0, mem_wr}, 32'd0);
            end
        join
        check("fetch_value_literal", memCon2iCache_return, 32'h4433_2211);

        // 2: sw 0xDEADBEEF to 0x2000
        lsb_access(1'b1, 2'b10, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1, d0);
        check("sw_phys_word", {phys_rd(32'h2003), phys_rd(32'h2002), phys_rd(32'h2001),
                               phys_rd(32'h2000)}, 32'hDEAD_BEEF);

        // 3: simultaneous requests after reset; LSB first, then alternate
        rst_in = 1'b1;
        sync();
        rst_in = 1'b0;
        fork
            begin
                ic_fetch(32'h0001_0040, 1'b0, d0);
                ic_fetch(32'h0001_0044, 1'b0, d1);
            end
            begin
                lsb_access(1'b0, 2'b10, 32'h0000_2000, 32'd0, 1'b0, d2);
                lsb_access(1'b0, 2'b00, 32'h0000_2002, 32'd0, 1'b0, d3);
            end
        join
        check("arb_lsb_first",   {31'd0, d2 < d0}, 32'd1);
        check("arb_ic_then_lsb", {31'd0, d0 < d3}, 32'd1);
        check("arb_lsb_then_ic", {31'd0, d3 < d1}, 32'd1);
        check("arb_resp_gap",    d0 - d2, 32'd8);

        // 4: sb to IO space while the IO buffer is full for 3 grant cycles
        io_buffer_full = 1'b1;
        n = cyc;
        fork
            begin
                lsb_push(1'b1, 2'b00, 32'h0003_0000, 32'h0000_00A7, 1'b1, 0, 3);
                wait_done(1'b1, d0);
                lsb2memCon_enable = 1'b0;
            end
            begin
                repeat (2) @(negedge clk_in);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_in);
                    check("io_stall_mem_wr", {31'd0, mem_wr}, 32'd0);
                end
                io_buffer_full = 1'b0;
            end
        join

        // 5: flush on 2nd READ cycle of a fetch; pending lh gets served next
        n = cyc;
        iCache2memCon_address = 32'h0001_0080;
        iCache2memCon_enable  = 1'b1;
        sync();
        lsb_push(1'b0, 2'b01, 32'h0000_2011, 32'd0, 1'b1, 0, 2);
        sync();
        clear_in = 1'b1;
        iCache2memCon_enable = 1'b0;
        sync();
        clear_in = 1'b0;
        wait_done(1'b1, d0);
        lsb2memCon_enable = 1'b0;
        check("lh_zero_ext", memCon2lsb_return & 32'hFFFF_0000, 32'd0);

        // 6a: rdy_in low for 2 cycles during a sw
        fork
            lsb_access(1'b1, 2'b10, 32'h0000_2100, 32'h1234_5678, 1'b0, d0);
            begin
                repeat (3) @(posedge clk_in);
                #1 rdy_in = 1'b0;
                @(negedge clk_in);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk_in);
                    check("freeze_mem_wr",   {31'd0, mem_wr}, 32'd1);
                    check("freeze_mem_dout", {24'd0, mem_dout}, 32'h0000_0056);
                    check("freeze_mem_a",    mem_a, 32'h0000_2101);
                end
                rdy_in = 1'b1;
            end
        join
        lsb_access(1'b0, 2'b10, 32'h0000_2100, 32'd0, 1'b0, d0);

        // 6b: reset in the middle of a fetch
        iCache2memCon_address = 32'h0001_0090;
        iCache2memCon_enable  = 1'b1;
        repeat (3) sync();
        check("pre_reset_mem_a", mem_a, 32'h0001_0091);
        rst_in = 1'b1;
        iCache2memCon_enable = 1'b0;
        sync();
        rst_in = 1'b0;
        @(negedge clk_in);
        reset_checks("midread_reset");
        repeat (8) sync();

        // Random phase: concurrent fetches (read-only region, incl. wrap),
        // LSB loads/stores and IO stores with a randomly full IO buffer.
        fork
            begin
                fork
                    for (int t = 0; t < 40; t++) begin
                        int dc;
                        logic [31:0] fa;
                        if ($urandom_range(0, 7) == 0) fa = 32'hFFFF_FFFC + $urandom_range(0, 3);
                        else fa = 32'h0001_0000 + $urandom_range(0, 255);
                        ic_fetch(fa, 1'b0, dc);
                        repeat ($urandom_range(0, 3)) sync();
                    end
                    for (int t = 0; t < 60; t++) begin
                        int dc;
                        logic [31:0] la;
                        bit w;
                        w = 1'($urandom_range(0, 1));
                        if ($urandom_range(0, 5) == 0) begin
                            la = 32'h0003_0000 + $urandom_range(0, 15);
                            w  = 1'b1;
                        end else begin
                            la = 32'h0000_2000 + $urandom_range(0, 63);
                        end
                        lsb_access(w, 2'($urandom_range(0, 3)), la, $urandom, 1'b0, dc);
                        repeat ($urandom_range(0, 2)) sync();
                    end
                join
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                sync();
                io_buffer_full = 1'($urandom_range(0, 1));
            end
        join
        io_buffer_full = 1'b0;

        repeat (10) sync();
        check("ic_queue_empty",  ic_q.size(), 32'd0);
        check("lsb_queue_empty", lsb_q.size(), 32'd0);
        check("wr_queue_empty",  wr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
